// File: rtl/regfile_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_arbiter_if
// Description : Bundle of requester-side and register-file-side signals
//               around the shared register-file port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_arbiter_if #(
    parameter int NREQ = 4
);
    // Requester side
    logic [NREQ-1:0]      iREQ;
    logic [NREQ-1:0]      iWE;
    logic [5*NREQ-1:0]    iRD;
    logic [5*NREQ-1:0]    iRS1;
    logic [5*NREQ-1:0]    iRS2;
    logic [32*NREQ-1:0]   iWDATA;
    logic [NREQ-1:0]      oGNT;
    logic [NREQ-1:0]      oVALID;
    logic [31:0]          oRDATA1;
    logic [31:0]          oRDATA2;
    logic                 oBUSY;

    // Register-file side
    logic [4:0]           o_X_RD;
    logic [4:0]           o_X_RS1;
    logic [4:0]           o_X_RS2;
    logic [31:0]          o_X_REG_IN;
    logic                 o_X_WE;
    logic [31:0]          i_X_REG_OUT1;
    logic [31:0]          i_X_REG_OUT2;

    // Everything outside the arbiter: requesters plus the register file
    modport master (
        output iREQ, iWE, iRD, iRS1, iRS2, iWDATA,
        input  oGNT, oVALID, oRDATA1, oRDATA2, oBUSY,
        input  o_X_RD, o_X_RS1, o_X_RS2, o_X_REG_IN, o_X_WE,
        output i_X_REG_OUT1, i_X_REG_OUT2
    );

    // The arbiter itself
    modport slave (
        input  iREQ, iWE, iRD, iRS1, iRS2, iWDATA,
        output oGNT, oVALID, oRDATA1, oRDATA2, oBUSY,
        output o_X_RD, o_X_RS1, o_X_RS2, o_X_REG_IN, o_X_WE,
        input  i_X_REG_OUT1, i_X_REG_OUT2
    );
endinterface
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Round-robin arbiter sharing one register-file access port
//               (two reads + one write) among NREQ requesters.
//               IDLE -> GRANT (1 cycle, port driven) -> RESP (1 cycle,
//               oVALID pulse, arbitrate next winner).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int NREQ = 4
) (
    input  wire logic              iCLK,
    input  wire logic              iRST,
    regfile_port_arbiter_if.slave  bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    localparam logic [NREQ-1:0] c_one      = NREQ'(1);
    localparam logic [IDXW-1:0] c_last_rst = IDXW'(NREQ - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDXW-1:0]  r_win;
    logic [IDXW-1:0]  r_last;
    logic [IDXW-1:0]  w_pick;
    logic             w_found;
    logic             w_load;
    logic [NREQ-1:0]  w_win_oh;
    logic [NREQ-1:0]  w_req_masked;

    logic             r_we;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata1;
    logic [31:0]      r_rdata2;

    assign w_win_oh = c_one << r_win;

    // Round-robin search starting just after the last served requester;
    // the requester being answered in RESP is excluded so it cannot win twice
    always_comb begin
        w_req_masked = bus.iREQ;
        if (r_state == c_st_resp) begin
            w_req_masked = bus.iREQ & ~w_win_oh;
        end
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_req_masked[(int'(r_last) + 1 + i) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = IDXW'((int'(r_last) + 1 + i) % NREQ);
            end
        end
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and all port outputs, decoded from the current state
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        bus.oGNT       = '0;
        bus.oVALID     = '0;
        bus.o_X_RD     = '0;
        bus.o_X_RS1    = '0;
        bus.o_X_RS2    = '0;
        bus.o_X_REG_IN = '0;
        bus.o_X_WE     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state_nxt = c_st_grant;
                    w_load      = 1'b1;
                end
            end
            c_st_grant: begin
                bus.oGNT       = w_win_oh;
                bus.o_X_RD     = r_rd;
                bus.o_X_RS1    = r_rs1;
                bus.o_X_RS2    = r_rs2;
                bus.o_X_REG_IN = r_wdata;
                // x0 is hard-wired zero, so a write to it is dropped here
                bus.o_X_WE     = r_we & (|r_rd);
                w_state_nxt    = c_st_resp;
            end
            c_st_resp: begin
                bus.oVALID = w_win_oh;
                if (w_found) begin
                    w_state_nxt = c_st_grant;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign bus.oBUSY   = (r_state != c_st_idle);
    assign bus.oRDATA1 = r_rdata1;
    assign bus.oRDATA2 = r_rdata2;

    // Latch the winner's fields on acceptance so later request changes
    // cannot disturb the access; capture read data as GRANT ends
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_win    <= '0;
            r_last   <= c_last_rst;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_wdata  <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            if (w_load) begin
                r_win   <= w_pick;
                r_we    <= bus.iWE[w_pick];
                r_rd    <= bus.iRD[int'(w_pick) * 5 +: 5];
                r_rs1   <= bus.iRS1[int'(w_pick) * 5 +: 5];
                r_rs2   <= bus.iRS2[int'(w_pick) * 5 +: 5];
                r_wdata <= bus.iWDATA[int'(w_pick) * 32 +: 32];
            end
            if (r_state == c_st_grant) begin
                r_rdata1 <= bus.i_X_REG_OUT1;
                r_rdata2 <= bus.i_X_REG_OUT2;
                r_last   <= r_win;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_port_arbiter
// Description : Directed self-checking bench for regfile_port_arbiter with a
//               small behavioural register file attached to the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;

    localparam int NREQ = 4;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic r_preload = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] r_regs [32];

    regfile_port_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_port_arbiter #(.NREQ(NREQ)) u_dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0;
            5:       return 32'h11;
            6:       return 32'h22;
            7:       return 32'h77;
            default: return 32'h100 + i;
        endcase
    endfunction

    // Register file: combinational read, write on rising edge, x0 fixed at 0
    always @(posedge iCLK) begin
        if (r_preload) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= init_val(i);
        end else if (bus.o_X_WE && bus.o_X_RD != 5'd0) begin
            r_regs[bus.o_X_RD] <= bus.o_X_REG_IN;
        end
    end
    assign bus.i_X_REG_OUT1 = (bus.o_X_RS1 == 5'd0) ? 32'h0 : r_regs[bus.o_X_RS1];
    assign bus.i_X_REG_OUT2 = (bus.o_X_RS2 == 5'd0) ? 32'h0 : r_regs[bus.o_X_RS2];

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.iREQ   = '0;
        bus.iWE    = '0;
        bus.iRD    = '0;
        bus.iRS1   = '0;
        bus.iRS2   = '0;
        bus.iWDATA = '0;

        // Reset state
        tick;
        tick;
        check("rst_gnt",   32'(bus.oGNT), 32'h0);
        check("rst_valid", 32'(bus.oVALID), 32'h0);
        check("rst_busy",  32'(bus.oBUSY), 32'h0);
        check("rst_rdata1", bus.oRDATA1, 32'h0);
        check("rst_rdata2", bus.oRDATA2, 32'h0);
        check("rst_xwe",   32'(bus.o_X_WE), 32'h0);
        check("rst_xrs1",  32'(bus.o_X_RS1), 32'h0);
        r_preload = 1'b0;
        iRST      = 1'b0;

        // Single read by requester 0
        bus.iREQ       = 4'b0001;
        bus.iRS1[4:0]  = 5'd5;
        bus.iRS2[4:0]  = 5'd6;
        tick;
        check("rd_gnt",   32'(bus.oGNT), 32'h1);
        check("rd_xrs1",  32'(bus.o_X_RS1), 32'd5);
        check("rd_busy",  32'(bus.oBUSY), 32'h1);
        check("rd_xwe",   32'(bus.o_X_WE), 32'h0);
        tick;
        check("rd_valid", 32'(bus.oVALID), 32'h1);
        check("rd_gnt0",  32'(bus.oGNT), 32'h0);
        check("rd_data1", bus.oRDATA1, 32'h11);
        check("rd_data2", bus.oRDATA2, 32'h22);
        bus.iREQ = '0;
        tick;
        check("rd_idle",  32'(bus.oBUSY), 32'h0);
        check("rd_vdrop", 32'(bus.oVALID), 32'h0);
        check("rd_hold",  bus.oRDATA1, 32'h11);

        // All four held from reset: order 0,1,2,3,0 with 2-cycle spacing
        iRST       = 1'b1;
        bus.iREQ   = 4'b1111;
        bus.iRS1   = {5'd11, 5'd10, 5'd9, 5'd8};
        bus.iRS2   = '0;
        tick;
        iRST = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_gnt%0d", k), 32'(bus.oGNT), 32'h1 << k);
            tick;
            check($sformatf("rr_valid%0d", k), 32'(bus.oVALID), 32'h1 << k);
            check($sformatf("rr_data%0d", k), bus.oRDATA1, 32'h108 + k);
            tick;
        end
        check("rr_gnt_wrap", 32'(bus.oGNT), 32'h1);
        bus.iREQ = '0;
        tick;
        check("rr_valid_wrap", 32'(bus.oVALID), 32'h1);
        check("rr_data_wrap",  bus.oRDATA1, 32'h108);
        tick;
        check("rr_idle", 32'(bus.oBUSY), 32'h0);

        // Requester 2 writes x7, reading x7 in the same access
        bus.iRD[14:10]    = 5'd7;
        bus.iRS1[14:10]   = 5'd7;
        bus.iWDATA[95:64] = 32'hDEADBEEF;
        bus.iWE           = 4'b0100;
        bus.iREQ          = 4'b0100;
        tick;
        check("wr_gnt",   32'(bus.oGNT), 32'h4);
        check("wr_xwe",   32'(bus.o_X_WE), 32'h1);
        check("wr_xrd",   32'(bus.o_X_RD), 32'd7);
        check("wr_xdata", bus.o_X_REG_IN, 32'hDEADBEEF);
        tick;
        check("wr_valid", 32'(bus.oVALID), 32'h4);
        check("wr_old",   bus.oRDATA1, 32'h77);
        bus.iREQ = '0;
        bus.iWE  = '0;
        tick;
        bus.iREQ = 4'b0100;
        tick;
        check("rb_gnt", 32'(bus.oGNT), 32'h4);
        check("rb_xwe", 32'(bus.o_X_WE), 32'h0);
        tick;
        check("rb_valid", 32'(bus.oVALID), 32'h4);
        check("rb_new",   bus.oRDATA1, 32'hDEADBEEF);
        bus.iREQ = '0;
        tick;

        // Requester 1 writes x0: write gated, access still completes
        bus.iRD[9:5]      = 5'd0;
        bus.iRS1[9:5]     = 5'd0;
        bus.iWDATA[63:32] = 32'hFFFFFFFF;
        bus.iWE           = 4'b0010;
        bus.iREQ          = 4'b0010;
        tick;
        check("x0_gnt", 32'(bus.oGNT), 32'h2);
        check("x0_xwe", 32'(bus.o_X_WE), 32'h0);
        tick;
        check("x0_valid", 32'(bus.oVALID), 32'h2);
        check("x0_read",  bus.oRDATA1, 32'h0);
        bus.iREQ = '0;
        bus.iWE  = '0;
        tick;
        check("x0_idle", 32'(bus.oBUSY), 32'h0);

        // Requester 3 pulses for one cycle; fields change during GRANT
        bus.iRS1[19:15] = 5'd5;
        bus.iRS2[19:15] = 5'd6;
        bus.iREQ        = 4'b1000;
        tick;
        check("pl_gnt",  32'(bus.oGNT), 32'h8);
        check("pl_xrs1", 32'(bus.o_X_RS1), 32'd5);
        check("pl_xrs2", 32'(bus.o_X_RS2), 32'd6);
        bus.iREQ        = '0;
        bus.iRS1[19:15] = 5'd9;
        bus.iRS2[19:15] = 5'd9;
        tick;
        check("pl_valid", 32'(bus.oVALID), 32'h8);
        check("pl_data1", bus.oRDATA1, 32'h11);
        check("pl_data2", bus.oRDATA2, 32'h22);
        tick;
        check("pl_idle", 32'(bus.oBUSY), 32'h0);
        check("pl_hold", bus.oRDATA1, 32'h11);

        // Reset asserted in the middle of GRANT
        bus.iREQ = 4'b0001;
        tick;
        check("ra_gnt", 32'(bus.oGNT), 32'h1);
        iRST = 1'b1;
        #1;
        check("ra_gnt0",   32'(bus.oGNT), 32'h0);
        check("ra_busy",   32'(bus.oBUSY), 32'h0);
        check("ra_xrs1",   32'(bus.o_X_RS1), 32'h0);
        check("ra_rdata1", bus.oRDATA1, 32'h0);
        bus.iREQ = 4'b1111;
        tick;
        check("ra_novalid", 32'(bus.oVALID), 32'h0);
        iRST = 1'b0;
        tick;
        check("ra_first", 32'(bus.oGNT), 32'h1);
        tick;
        check("ra_valid", 32'(bus.oVALID), 32'h1);
        check("ra_data",  bus.oRDATA1, 32'h108);
        bus.iREQ = '0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the register-file port.
REQ-002 SHALL have port iCLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port iRST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iREQ  input  NREQ  per-requester access request.
REQ-005 SHALL have port iWE  input  NREQ  per-requester write intent.
REQ-006 SHALL have ports iRD, iRS1, iRS2  input  5*NREQ each  packed register addresses, requester k in bits [5k+4:5k].
REQ-007 SHALL have port iWDATA  input  32*NREQ  packed write data, requester k in bits [32k+31:32k].
REQ-008 SHALL have port oGNT  output  NREQ  one-hot grant.
REQ-009 SHALL have port oVALID  output  NREQ  one-hot response-valid pulse.
REQ-010 SHALL have ports oRDATA1, oRDATA2  output  32 each  shared read data.
REQ-011 SHALL have port oBUSY  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports o_X_RD, o_X_RS1, o_X_RS2  output  5 each; o_X_REG_IN  output  32; o_X_WE  output  1; all to the register file.
REQ-013 SHALL have ports i_X_REG_OUT1, i_X_REG_OUT2  input  32 each  register-file read data, combinational from o_X_RS1/o_X_RS2.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, RESP.
REQ-015 In IDLE with any iREQ bit high, SHALL pick winner w round-robin, searching from (last+1) mod NREQ upward with wrap. It SHALL latch w and that requester's iWE, iRD, iRS1, iRS2 and iWDATA, then move to GRANT.
REQ-016 In IDLE with iREQ all zero, SHALL stay in IDLE.
REQ-017 In GRANT, SHALL drive oGNT[w]=1 and o_X_* from the latched fields, with o_X_WE = latched WE AND (latched RD != 0).
REQ-018 At the end of GRANT, SHALL capture i_X_REG_OUT1/2 into oRDATA1/2, update last=w, and move to RESP; GRANT lasts exactly 1 cycle.
REQ-019 In RESP, SHALL drive oVALID[w]=1 for exactly 1 cycle; oGNT=0.
REQ-020 In RESP, SHALL arbitrate as in REQ-015 with iREQ[w] masked. On a winner it goes to GRANT, otherwise to IDLE.
REQ-021 Latency: a request accepted in IDLE gets oGNT 1 cycle later and oVALID 2 cycles later. Back-to-back throughput is 1 access per 2 cycles.
REQ-022 A requester SHALL hold iREQ and its fields until its oVALID pulse and drop iREQ the cycle after. A held iREQ is re-arbitrated from IDLE.
REQ-023 Outside GRANT, o_X_RD, o_X_RS1, o_X_RS2, o_X_REG_IN and o_X_WE SHALL be 0.
REQ-024 oRDATA1/2 SHALL hold the last captured value until the next capture.
REQ-025 Read data SHALL reflect register contents before the same access's write; a write to RD=0 SHALL be suppressed but still complete with oVALID.
REQ-026 Request changes while in GRANT SHALL NOT affect the current access.

Reset
REQ-027 iRST high SHALL immediately force state IDLE and last=NREQ-1, with all outputs 0: oGNT, oVALID, oRDATA1/2, oBUSY, o_X_*.
REQ-028 Reset mid-GRANT or mid-RESP SHALL abort the access with no oVALID pulse; the register-file write is gated off by o_X_WE=0.
REQ-029 After iRST deasserts, requester 0 SHALL win the first simultaneous arbitration.

Verification
REQ-030 Single read:
- iREQ=0001, iRS1=5, iRS2=6, regs x5=0x11, x6=0x22.
- Required: oGNT=0001 at +1, o_X_RS1=5.
- Required: oVALID=0001 at +2, oRDATA1=0x11, oRDATA2=0x22.
REQ-031 All four requesters held high from reset: grants SHALL follow the order 0,1,2,3,0, each oGNT spaced 2 cycles apart.
REQ-032 Write then read:
- Requester 2 with iWE=1, iRD=7, iWDATA=0xDEADBEEF, iRS1=7.
- Required: o_X_WE=1 in GRANT, oRDATA1 = old x7.
- A following read of x7 SHALL return 0xDEADBEEF.
REQ-033 Write with iRD=0, iWE=1: o_X_WE SHALL stay 0, oVALID SHALL still pulse, and x0 SHALL read 0 afterwards.
REQ-034 iRST asserted during GRANT: all outputs 0 in the same cycle, no oVALID. After release with iREQ=1111, requester 0 SHALL be granted first.
REQ-035 iREQ pulses high for one cycle in IDLE then drops: the access SHALL still complete with oGNT at +1 and oVALID at +2 from the latched fields.
